// File: rtl/wb_regfile_if.sv
// Writeback-stage bus: MEM/WB pipeline inputs, decode read ports, forwarding and retire-count outputs.
interface wb_regfile_if #(
   parameter int unsigned RET_CNT_W = 32
);
   logic                 instr_retired_wb_i;
   logic                 reg_wr_wb_i;
   logic                 mem_to_reg_wb_i;
   logic [4:0]           rd_wb_i;
   logic [31:0]          res_alu_wb_i;
   logic [31:0]          read_data_wb_i;
   logic [4:0]           rs_addr_wb_i;
   logic [4:0]           rt_addr_wb_i;
   logic [31:0]          rs_data_wb_o;
   logic [31:0]          rt_data_wb_o;
   logic                 wb_en_wb_o;
   logic [4:0]           wb_rd_wb_o;
   logic [31:0]          wb_data_wb_o;
   logic [RET_CNT_W-1:0] ret_cnt_wb_o;

   modport master (
      output instr_retired_wb_i, reg_wr_wb_i, mem_to_reg_wb_i, rd_wb_i,
             res_alu_wb_i, read_data_wb_i, rs_addr_wb_i, rt_addr_wb_i,
      input  rs_data_wb_o, rt_data_wb_o, wb_en_wb_o, wb_rd_wb_o,
             wb_data_wb_o, ret_cnt_wb_o
   );

   modport slave (
      input  instr_retired_wb_i, reg_wr_wb_i, mem_to_reg_wb_i, rd_wb_i,
             res_alu_wb_i, read_data_wb_i, rs_addr_wb_i, rt_addr_wb_i,
      output rs_data_wb_o, rt_data_wb_o, wb_en_wb_o, wb_rd_wb_o,
             wb_data_wb_o, ret_cnt_wb_o
   );
endinterface

// File: rtl/wb_regfile.sv
// MIPS writeback stage: result select, 32x32 GPR file with write-before-read bypass,
// forwarding bus and retired-instruction counter.
module wb_regfile #(
   parameter int unsigned RET_CNT_W = 32,
   parameter int unsigned NUM_REGS  = 32
) (
   input  logic         clk,
   input  logic         reset,
   wb_regfile_if.slave  bus
);
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;

   logic [DATA_W-1:0]    regs [NUM_REGS];
   logic [RET_CNT_W-1:0] ret_cnt;
   logic [DATA_W-1:0]    wb_data;
   logic                 wb_en;

   // Writeback value and effective enable; r0 is never a legal target.
   always_comb begin
      wb_data = bus.mem_to_reg_wb_i ? bus.read_data_wb_i : bus.res_alu_wb_i;
      wb_en   = bus.instr_retired_wb_i & bus.reg_wr_wb_i & (bus.rd_wb_i != ADDR_W'(0));
   end

   function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
      if (addr == ADDR_W'(0))
         return '0;
      else if (wb_en && (addr == bus.rd_wb_i))
         return wb_data;
      else
         return regs[addr];
   endfunction

   always_comb begin
      bus.rs_data_wb_o = read_port(bus.rs_addr_wb_i);
      bus.rt_data_wb_o = read_port(bus.rt_addr_wb_i);
      bus.wb_en_wb_o   = wb_en;
      bus.wb_rd_wb_o   = bus.rd_wb_i;
      bus.wb_data_wb_o = wb_data;
      bus.ret_cnt_wb_o = ret_cnt;
   end

   // Reset wins over any same-edge write or retire.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_REGS; i++)
            regs[i] <= '0;
         ret_cnt <= '0;
      end else begin
         if (wb_en)
            regs[bus.rd_wb_i] <= wb_data;
         if (bus.instr_retired_wb_i)
            ret_cnt <= ret_cnt + RET_CNT_W'(1);
      end
   end
endmodule
